// File: rtl/mem_bus_arbiter_if.sv
// Cache-side request channels and RAM-side port of the memory bus arbiter.
// The slave modport is the arbiter's view; master is the view of the
// surrounding caches plus RAM model.
interface mem_bus_arbiter_if #(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [CPUS-1:0]    iREN;
  logic [CPUS*AW-1:0] iaddr;
  logic [CPUS-1:0]    iwait;
  logic [CPUS*DW-1:0] iload;
  logic [CPUS-1:0]    dREN;
  logic [CPUS-1:0]    dWEN;
  logic [CPUS*AW-1:0] daddr;
  logic [CPUS*DW-1:0] dstore;
  logic [CPUS-1:0]    dwait;
  logic [CPUS*DW-1:0] dload;
  logic               ramREN;
  logic               ramWEN;
  logic [AW-1:0]      ramaddr;
  logic [DW-1:0]      ramstore;
  logic [DW-1:0]      ramload;
  logic [1:0]         ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one RAM port between the instruction and data channels of CPUS
// cores. Data requests beat instruction fetches; within a class the cores
// rotate round-robin starting from rr. One transfer at a time, with an IDLE
// cycle between transfers. The RAM side and the wait/load returns are driven
// combinationally from the owner's live inputs while a transfer is open.
module mem_bus_arbiter #(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  mem_bus_arbiter_if.slave bus
);
  localparam int         OW         = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic {IDLE, XFER} state_t;
  typedef enum logic [1:0] {INSTR, DREAD, DWRITE} kind_t;

  state_t        state, state_nx;
  kind_t         kind, kind_nx, pick_kind;
  logic [OW-1:0] owner, owner_nx, rr, rr_nx;
  logic [OW-1:0] pick, owner_inc;
  logic [CPUS-1:0] dreq, cls_req;
  logic          any_d, found, live;

  assign dreq      = bus.dREN | bus.dWEN;
  assign any_d     = |dreq;
  assign cls_req   = any_d ? dreq : bus.iREN;
  assign owner_inc = (int'(owner) == CPUS - 1) ? '0 : owner + OW'(1);

  // Rotating search for the first requester of the winning class from rr up.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < CPUS; i++) begin
      if (!found && cls_req[(int'(rr) + i) % CPUS]) begin
        found = 1'b1;
        pick  = OW'((int'(rr) + i) % CPUS);
      end
    end
  end

  // Kind of the picked transfer; a core asking to read and write at once writes.
  always_comb begin
    if (!any_d)                pick_kind = INSTR;
    else if (bus.dWEN[pick])   pick_kind = DWRITE;
    else                       pick_kind = DREAD;
  end

  // Owner still asserting the request it was granted for.
  always_comb begin
    case (kind)
      INSTR:   live = bus.iREN[owner];
      DREAD:   live = bus.dREN[owner];
      default: live = bus.dWEN[owner];
    endcase
  end

  // Control state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      owner <= '0;
      kind  <= INSTR;
      rr    <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      kind  <= kind_nx;
      rr    <= rr_nx;
    end
  end

  // Next-state logic plus RAM drive and wait/load returns.
  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    kind_nx      = kind;
    rr_nx        = rr;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.iload    = '0;
    bus.dload    = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx = XFER;
          owner_nx = pick;
          kind_nx  = pick_kind;
        end
      end
      default: begin
        // A withdrawn request aborts the transfer: nothing reaches the RAM.
        if (!live) begin
          state_nx = IDLE;
        end else begin
          case (kind)
            INSTR: begin
              bus.ramREN  = 1'b1;
              bus.ramaddr = bus.iaddr[int'(owner)*AW +: AW];
            end
            DREAD: begin
              bus.ramREN  = 1'b1;
              bus.ramaddr = bus.daddr[int'(owner)*AW +: AW];
            end
            default: begin
              bus.ramWEN   = 1'b1;
              bus.ramaddr  = bus.daddr[int'(owner)*AW +: AW];
              bus.ramstore = bus.dstore[int'(owner)*DW +: DW];
            end
          endcase
          if (bus.ramstate == RAM_ACCESS) begin
            state_nx = IDLE;
            rr_nx    = owner_inc;
            case (kind)
              INSTR: begin
                bus.iwait[owner]                 = 1'b0;
                bus.iload[int'(owner)*DW +: DW]  = bus.ramload;
              end
              DREAD: begin
                bus.dwait[owner]                 = 1'b0;
                bus.dload[int'(owner)*DW +: DW]  = bus.ramload;
              end
              default: bus.dwait[owner] = 1'b0;
            endcase
          end else if (bus.ramstate == RAM_ERROR) begin
            // ERROR drops the transfer; the requester re-arbitrates from IDLE.
            state_nx = IDLE;
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by randomized
// transactions checked against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int CPUS = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int RW   = 2 + AW + DW;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  mem_bus_arbiter_if #(.CPUS(CPUS), .AW(AW), .DW(DW)) bus();

  mem_bus_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  // ---------------- stimulus and observation utilities ----------------
  task automatic clear_inputs();
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ramload = '0; bus.ramstate = 2'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  function automatic logic [RW-1:0] ram_obs();
    return {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore};
  endfunction

  function automatic logic [AW-1:0] get_iaddr(int c);
    return bus.iaddr[c*AW +: AW];
  endfunction

  function automatic logic [AW-1:0] get_daddr(int c);
    return bus.daddr[c*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] get_dstore(int c);
    return bus.dstore[c*DW +: DW];
  endfunction

  // ---------------- reference model ----------------
  // Expected RAM drive for an open transfer of the given owner and kind
  // (0 instruction, 1 data read, 2 data write).
  function automatic logic [RW-1:0] model_ram(int own, int knd);
    if (knd == 0) return {1'b1, 1'b0, get_iaddr(own), {DW{1'b0}}};
    if (knd == 1) return {1'b1, 1'b0, get_daddr(own), {DW{1'b0}}};
    return {1'b0, 1'b1, get_daddr(own), get_dstore(own)};
  endfunction

  // Data class beats fetches; within the class take the first requester at
  // or after the round-robin pointer, wrapping around.
  task automatic model_grant(input int ptr, output int own, output int knd);
    bit any_d;
    bit got;
    any_d = |(bus.dREN | bus.dWEN);
    got = 0;
    own = 0;
    knd = 0;
    for (int k = 0; k < CPUS; k++) begin
      int c;
      c = (ptr + k) % CPUS;
      if (!got && (any_d ? (bus.dREN[c] || bus.dWEN[c]) : bus.iREN[c])) begin
        got = 1;
        own = c;
        knd = !any_d ? 0 : (bus.dWEN[c] ? 2 : 1);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    nRST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      bus.iREN = CPUS'($urandom); bus.dREN = CPUS'($urandom); bus.dWEN = CPUS'($urandom);
      bus.iaddr = {$urandom, $urandom}; bus.daddr = {$urandom, $urandom};
      bus.dstore = {$urandom, $urandom}; bus.ramstate = 2'd2; bus.ramload = $urandom;
      #1;
      checks++;
      if (ram_obs() !== '0) begin
        errors++; $display("FAIL reset_ram: got %h expected 0", ram_obs());
      end
      checks++;
      if ({bus.iwait, bus.dwait} !== '1) begin
        errors++; $display("FAIL reset_waits: got %b expected all 1", {bus.iwait, bus.dwait});
      end
      checks++;
      if ({bus.iload, bus.dload} !== '0) begin
        errors++; $display("FAIL reset_loads: got %h expected 0", {bus.iload, bus.dload});
      end
    end
    clear_inputs();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_ifetch();
    @(negedge CLK);
    bus.iREN = 2'b01; bus.iaddr[0 +: AW] = 32'h40;
    #1;
    checks++;
    if (ram_obs() !== '0) begin
      errors++; $display("FAIL ifetch_idle_ram: got %h expected 0", ram_obs());
    end
    @(negedge CLK);
    bus.ramstate = 2'd2; bus.ramload = 32'h8C220004;
    #1;
    checks++;
    if (ram_obs() !== {1'b1, 1'b0, 32'h40, 32'h0}) begin
      errors++; $display("FAIL ifetch_ram: got %h expected %h", ram_obs(), {1'b1, 1'b0, 32'h40, 32'h0});
    end
    checks++;
    if (bus.iwait !== 2'b10 || bus.dwait !== 2'b11) begin
      errors++; $display("FAIL ifetch_wait: got i=%b d=%b expected i=10 d=11", bus.iwait, bus.dwait);
    end
    checks++;
    if (bus.iload !== {32'h0, 32'h8C220004}) begin
      errors++; $display("FAIL ifetch_load: got %h expected 000000008c220004", bus.iload);
    end
    @(negedge CLK);
    bus.ramstate = 2'd2;
    #1;
    checks++;
    if (ram_obs() !== '0 || bus.iwait !== 2'b11) begin
      errors++; $display("FAIL ifetch_back_idle: got ram=%h iwait=%b expected 0 and 11", ram_obs(), bus.iwait);
    end
    clear_inputs();
  endtask

  task automatic test_data_priority();
    @(negedge CLK);
    bus.iREN = 2'b01; bus.iaddr[0 +: AW] = 32'h80;
    bus.dWEN = 2'b10; bus.daddr[AW +: AW] = 32'h100; bus.dstore[DW +: DW] = 32'hDEADBEEF;
    #1;
    checks++;
    if (ram_obs() !== '0 || {bus.iwait, bus.dwait} !== 4'b1111) begin
      errors++; $display("FAIL prio_idle: got ram=%h waits=%b expected 0 and 1111", ram_obs(), {bus.iwait, bus.dwait});
    end
    @(negedge CLK);
    bus.ramstate = 2'd2;
    #1;
    checks++;
    if (ram_obs() !== {1'b0, 1'b1, 32'h100, 32'hDEADBEEF}) begin
      errors++; $display("FAIL prio_write_ram: got %h expected %h", ram_obs(), {1'b0, 1'b1, 32'h100, 32'hDEADBEEF});
    end
    checks++;
    if (bus.dwait !== 2'b01 || bus.iwait !== 2'b11) begin
      errors++; $display("FAIL prio_write_wait: got d=%b i=%b expected d=01 i=11", bus.dwait, bus.iwait);
    end
    @(negedge CLK);
    bus.dWEN = 2'b00; bus.ramstate = 2'd0;
    #1;
    checks++;
    if (ram_obs() !== '0 || bus.iwait !== 2'b11) begin
      errors++; $display("FAIL prio_gap: got ram=%h iwait=%b expected 0 and 11", ram_obs(), bus.iwait);
    end
    @(negedge CLK);
    bus.ramstate = 2'd1;
    #1;
    checks++;
    if (ram_obs() !== {1'b1, 1'b0, 32'h80, 32'h0} || bus.iwait !== 2'b11) begin
      errors++; $display("FAIL prio_fetch_busy: got ram=%h iwait=%b expected %h and 11", ram_obs(), bus.iwait, {1'b1, 1'b0, 32'h80, 32'h0});
    end
    @(negedge CLK);
    bus.ramstate = 2'd2; bus.ramload = 32'h13579BDF;
    #1;
    checks++;
    if (bus.iwait !== 2'b10 || bus.iload !== {32'h0, 32'h13579BDF}) begin
      errors++; $display("FAIL prio_fetch_done: got iwait=%b iload=%h expected 10 and 0000000013579bdf", bus.iwait, bus.iload);
    end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] a;
    logic [CPUS-1:0] exp_dw;
    logic [CPUS*DW-1:0] exp_dl;
    do_reset();
    bus.dREN = 2'b11; bus.daddr = {32'h2000, 32'h1000};
    #1;
    checks++;
    if (ram_obs() !== '0) begin
      errors++; $display("FAIL rr_idle: got %h expected 0", ram_obs());
    end
    for (int k = 0; k < 3; k++) begin
      int own;
      own = k % 2;
      a = (own == 1) ? 32'h2000 : 32'h1000;
      for (int b = 0; b < 2; b++) begin
        @(negedge CLK);
        bus.ramstate = 2'd1;
        #1;
        checks++;
        if (ram_obs() !== {1'b1, 1'b0, a, 32'h0} || bus.dwait !== 2'b11) begin
          errors++; $display("FAIL rr_busy%0d: got ram=%h dwait=%b expected %h and 11", k, ram_obs(), bus.dwait, {1'b1, 1'b0, a, 32'h0});
        end
      end
      @(negedge CLK);
      bus.ramstate = 2'd2; bus.ramload = 32'hA0000000 + k;
      #1;
      exp_dw = '1; exp_dw[own] = 1'b0;
      exp_dl = '0; exp_dl[own*DW +: DW] = 32'hA0000000 + k;
      checks++;
      if (ram_obs() !== {1'b1, 1'b0, a, 32'h0} || bus.dwait !== exp_dw || bus.dload !== exp_dl) begin
        errors++; $display("FAIL rr_done%0d: got ram=%h dwait=%b dload=%h expected %h %b %h", k, ram_obs(), bus.dwait, bus.dload, {1'b1, 1'b0, a, 32'h0}, exp_dw, exp_dl);
      end
      @(negedge CLK);
      bus.ramstate = 2'd0;
      #1;
      checks++;
      if (ram_obs() !== '0 || bus.dwait !== 2'b11) begin
        errors++; $display("FAIL rr_gap%0d: got ram=%h dwait=%b expected 0 and 11", k, ram_obs(), bus.dwait);
      end
      if (k == 2) bus.dREN = 2'b00;
    end
    clear_inputs();
  endtask

  task automatic test_error_retry();
    @(negedge CLK);
    bus.dREN = 2'b10; bus.daddr = {32'h200, 32'h300};
    @(negedge CLK);
    bus.ramstate = 2'd3;
    #1;
    checks++;
    if (ram_obs() !== {1'b1, 1'b0, 32'h200, 32'h0} || bus.dwait !== 2'b11 || bus.dload !== '0) begin
      errors++; $display("FAIL err_xfer: got ram=%h dwait=%b dload=%h expected %h 11 0", ram_obs(), bus.dwait, bus.dload, {1'b1, 1'b0, 32'h200, 32'h0});
    end
    @(negedge CLK);
    bus.dREN = 2'b11; bus.ramstate = 2'd0;
    #1;
    checks++;
    if (ram_obs() !== '0 || bus.dwait !== 2'b11) begin
      errors++; $display("FAIL err_idle: got ram=%h dwait=%b expected 0 and 11", ram_obs(), bus.dwait);
    end
    @(negedge CLK);
    bus.ramstate = 2'd2; bus.ramload = 32'hCAFE0001;
    #1;
    checks++;
    if (ram_obs() !== {1'b1, 1'b0, 32'h200, 32'h0} || bus.dwait !== 2'b01 || bus.dload !== {32'hCAFE0001, 32'h0}) begin
      errors++; $display("FAIL err_retry: got ram=%h dwait=%b dload=%h expected core1 addr 200, 01, cafe0001", ram_obs(), bus.dwait, bus.dload);
    end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_withdraw();
    @(negedge CLK);
    bus.iREN = 2'b01; bus.iaddr = {32'h88, 32'h44};
    @(negedge CLK);
    bus.ramstate = 2'd1;
    #1;
    checks++;
    if (ram_obs() !== {1'b1, 1'b0, 32'h44, 32'h0}) begin
      errors++; $display("FAIL wd_busy: got %h expected %h", ram_obs(), {1'b1, 1'b0, 32'h44, 32'h0});
    end
    @(negedge CLK);
    bus.iREN = 2'b00;
    #1;
    checks++;
    if (ram_obs() !== '0 || bus.iwait !== 2'b11) begin
      errors++; $display("FAIL wd_drop: got ram=%h iwait=%b expected 0 and 11", ram_obs(), bus.iwait);
    end
    @(negedge CLK);
    bus.iREN = 2'b11;
    #1;
    checks++;
    if (ram_obs() !== '0 || {bus.iwait, bus.dwait} !== 4'b1111) begin
      errors++; $display("FAIL wd_idle: got ram=%h waits=%b expected 0 and 1111", ram_obs(), {bus.iwait, bus.dwait});
    end
    @(negedge CLK);
    bus.ramstate = 2'd2; bus.ramload = 32'h55;
    #1;
    checks++;
    if (ram_obs() !== {1'b1, 1'b0, 32'h44, 32'h0} || bus.iwait !== 2'b10 || bus.iload !== {32'h0, 32'h55}) begin
      errors++; $display("FAIL wd_regrant: got ram=%h iwait=%b iload=%h expected core0 addr 44, 10, 55", ram_obs(), bus.iwait, bus.iload);
    end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_reset_mid_xfer();
    @(negedge CLK);
    bus.dWEN = 2'b10; bus.daddr[AW +: AW] = 32'h500; bus.dstore[DW +: DW] = 32'h12345678;
    @(negedge CLK);
    bus.ramstate = 2'd1;
    #1;
    checks++;
    if (ram_obs() !== {1'b0, 1'b1, 32'h500, 32'h12345678}) begin
      errors++; $display("FAIL rst_mid_write: got %h expected %h", ram_obs(), {1'b0, 1'b1, 32'h500, 32'h12345678});
    end
    #2;
    nRST = 1'b0; bus.ramstate = 2'd2;
    #1;
    checks++;
    if (ram_obs() !== '0 || {bus.iwait, bus.dwait} !== 4'b1111 || {bus.iload, bus.dload} !== '0) begin
      errors++; $display("FAIL rst_mid_drop: got ram=%h waits=%b expected 0 and 1111", ram_obs(), {bus.iwait, bus.dwait});
    end
    @(negedge CLK);
    #1;
    checks++;
    if (bus.dwait !== 2'b11 || ram_obs() !== '0) begin
      errors++; $display("FAIL rst_mid_hold: got ram=%h dwait=%b expected 0 and 11", ram_obs(), bus.dwait);
    end
    @(negedge CLK);
    clear_inputs();
    bus.iREN = 2'b11; bus.iaddr = {32'h700, 32'h600};
    nRST = 1'b1;
    @(negedge CLK);
    bus.ramstate = 2'd2; bus.ramload = 32'h77;
    #1;
    checks++;
    if (ram_obs() !== {1'b1, 1'b0, 32'h600, 32'h0} || bus.iwait !== 2'b10) begin
      errors++; $display("FAIL rst_mid_rr: got ram=%h iwait=%b expected core0 addr 600 and 10", ram_obs(), bus.iwait);
    end
    @(negedge CLK);
    clear_inputs();
  endtask

  task automatic test_random();
    int m_rr, own, knd, nbusy, outcome;
    logic [DW-1:0] ld;
    logic [RW-1:0] exp_ram;
    logic [CPUS-1:0] exp_iw, exp_dw;
    logic [CPUS*DW-1:0] exp_il, exp_dl;
    do_reset();
    m_rr = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge CLK);
      for (int c = 0; c < CPUS; c++) begin
        bus.iREN[c] = ($urandom_range(0, 1) == 1);
        bus.dREN[c] = ($urandom_range(0, 2) == 0);
        bus.dWEN[c] = ($urandom_range(0, 2) == 0);
        bus.iaddr[c*AW +: AW] = $urandom;
        bus.daddr[c*AW +: AW] = $urandom;
        bus.dstore[c*DW +: DW] = $urandom;
      end
      if ((bus.iREN | bus.dREN | bus.dWEN) == '0) bus.iREN[$urandom_range(0, CPUS-1)] = 1'b1;
      bus.ramstate = 2'($urandom_range(0, 3));
      bus.ramload = $urandom;
      #1;
      checks++;
      if (ram_obs() !== '0 || {bus.iwait, bus.dwait} !== '1 || {bus.iload, bus.dload} !== '0) begin
        errors++; $display("FAIL rnd_idle%0d: got ram=%h waits=%b expected 0 and all 1", t, ram_obs(), {bus.iwait, bus.dwait});
      end
      model_grant(m_rr, own, knd);
      nbusy = $urandom_range(0, 2);
      for (int b = 0; b < nbusy; b++) begin
        @(negedge CLK);
        bus.ramstate = 2'($urandom_range(0, 1));
        #1;
        exp_ram = model_ram(own, knd);
        checks++;
        if (ram_obs() !== exp_ram || {bus.iwait, bus.dwait} !== '1) begin
          errors++; $display("FAIL rnd_hold%0d: got ram=%h waits=%b expected %h and all 1", t, ram_obs(), {bus.iwait, bus.dwait}, exp_ram);
        end
      end
      @(negedge CLK);
      outcome = $urandom_range(0, 9);
      ld = $urandom;
      bus.ramload = ld;
      if (outcome < 6) bus.ramstate = 2'd2;
      else if (outcome < 8) bus.ramstate = 2'd3;
      else begin
        bus.ramstate = 2'($urandom_range(0, 3));
        if (knd == 0) bus.iREN[own] = 1'b0;
        else if (knd == 1) bus.dREN[own] = 1'b0;
        else bus.dWEN[own] = 1'b0;
      end
      #1;
      exp_ram = (outcome >= 8) ? '0 : model_ram(own, knd);
      exp_iw = '1; exp_dw = '1; exp_il = '0; exp_dl = '0;
      if (outcome < 6) begin
        if (knd == 0) begin exp_iw[own] = 1'b0; exp_il[own*DW +: DW] = ld; end
        else begin
          exp_dw[own] = 1'b0;
          if (knd == 1) exp_dl[own*DW +: DW] = ld;
        end
        m_rr = (own + 1) % CPUS;
      end
      checks++;
      if (ram_obs() !== exp_ram) begin
        errors++; $display("FAIL rnd_ram%0d: got %h expected %h", t, ram_obs(), exp_ram);
      end
      checks++;
      if (bus.iwait !== exp_iw || bus.dwait !== exp_dw) begin
        errors++; $display("FAIL rnd_wait%0d: got i=%b d=%b expected i=%b d=%b", t, bus.iwait, bus.dwait, exp_iw, exp_dw);
      end
      checks++;
      if (bus.iload !== exp_il || bus.dload !== exp_dl) begin
        errors++; $display("FAIL rnd_load%0d: got i=%h d=%h expected i=%h d=%h", t, bus.iload, bus.dload, exp_il, exp_dl);
      end
    end
    @(negedge CLK);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    nRST = 1'b0;
    test_reset();
    test_ifetch();
    test_data_priority();
    test_round_robin();
    test_error_retry();
    test_withdraw();
    test_reset_mid_xfer();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
